// File: rtl/exp_pkg.sv
// Shared definitions for the exponentiation sequencer.
// Holds the FSM encoding, default widths and the z=1 init constant.
package exp_pkg;

    localparam int EW_DEF = 8;
    localparam int DW_DEF = 64;
    localparam int AW_DEF = 5;

    // Value the step stage starts from while init is high.
    localparam int Z_INIT = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Counter width that stays legal for a count of 1.
    function automatic int cw(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/exp_round_ctr.sv
// Step and round counters for the square-and-multiply sequencer.
// Ports: clk, rst, clr (restart at 0/0), en (advance), round,
//        step_tc (last step of round), round_tc (last round).
module exp_round_ctr
    import exp_pkg::*;
#(
    parameter int EW       = EW_DEF,
    parameter int STEP_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [cw(EW)-1:0] round,
    output logic              step_tc,
    output logic              round_tc
);

    localparam int SW = cw(STEP_LAT);
    localparam int RW = cw(EW);

    logic [SW-1:0] step;

    assign step_tc  = (step == SW'(STEP_LAT - 1));
    assign round_tc = (round == RW'(EW - 1));

    // The round index parks on EW-1 after the final round so it
    // never wraps back to 0 while the FSM sits in FINISH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step  <= '0;
            round <= '0;
        end else if (clr) begin
            step  <= '0;
            round <= '0;
        end else if (en) begin
            if (step_tc) begin
                step <= '0;
                if (!round_tc)
                    round <= round + 1'b1;
            end else begin
                step <= step + 1'b1;
            end
        end
    end

endmodule

// File: rtl/exp_seq.sv
// Control sequencer for MSB-first square-and-multiply exponentiation.
// Ports: clk, rst, start, e, zz (step-stage product) in; busy, init,
//        e_round, round, wr_en, wr_addr, result, done out.
module exp_seq
    import exp_pkg::*;
#(
    parameter int EW       = EW_DEF,
    parameter int DW       = DW_DEF,
    parameter int STEP_LAT = 1,
    parameter int AW       = AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [EW-1:0]     e,
    input  logic [DW-1:0]     zz,
    output logic              busy,
    output logic              init,
    output logic              e_round,
    output logic [cw(EW)-1:0] round,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [DW-1:0]     result,
    output logic              done
);

    localparam int RW = cw(EW);

    state_t        state;
    state_t        state_n;
    logic [EW-1:0] e_reg;
    logic          clr;
    logic          run;
    logic          step_tc;
    logic          round_tc;

    exp_round_ctr #(
        .EW       (EW),
        .STEP_LAT (STEP_LAT)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .en       (run),
        .round    (round),
        .step_tc  (step_tc),
        .round_tc (round_tc)
    );

    always_comb begin
        state_n = state;
        clr     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    clr     = 1'b1;
                end
            end
            RUN: begin
                if (step_tc && round_tc)
                    state_n = FINISH;
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign run     = (state == RUN);
    assign busy    = (state != IDLE);
    assign init    = run && (round == '0);
    assign e_round = run ? e_reg[RW'(EW - 1) - round] : 1'b0;
    assign wr_en   = run && step_tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            e_reg   <= '0;
            wr_addr <= '0;
            result  <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_n;
            done  <= (state == FINISH);
            if (state == IDLE && start)
                e_reg <= e;
            if (wr_en)
                wr_addr <= wr_addr + 1'b1;
            // zz already holds the last round's product here.
            if (state == FINISH)
                result <= zz;
        end
    end

endmodule
